mm_seq_ctrl: RTL

Job sequencer for the matrix-multiply accelerator, placed between a command source (firmware register block or DMA) and the accelerator's AXI-Lite slave and AXI-Stream ports. For each accepted command it:
- programs the data-length register and sets ap_start over AXI-Lite;
- forwards a counted number of operand words into ss_* and a counted number of result words from sm_* to dst_*;
- polls ap_done and reports completion or error.

---
 rtl/mm_seq_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mm_seq_ctrl
//
// Job sequencer for the matrix-multiply accelerator. It sits between a command
// source and the accelerator's AXI-Lite slave and AXI-Stream ports. For each
// accepted command it:
//   1. writes the data-length register, then writes ap_start (AXI-Lite);
//   2. forwards exactly cmd_in_len operand words src_* -> ss_* and exactly
//      cmd_out_len result words sm_* -> dst_*, with both paths running
//      concurrently;
//   3. polls ap_ctrl until ap_done is seen or POLL_MAX reads have been made,
//      then pulses done with err.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         job request handshake
//   cmd_in_len, cmd_out_len     operand / result word counts (CW bits)
//   aw*/w*                      AXI-Lite write address / data channels
//   ar*/r*                      AXI-Lite read address / data channels
//   src_t*                      operand source (slave side of this block)
//   ss_t*                       operand stream into the accelerator
//   sm_t*                       result stream out of the accelerator
//   dst_t*                      result sink (master side of this block)
//   busy, done, err             job status; err is valid with the done pulse
//
// AXI-Lite outputs and status are registered; the stream lanes are
// combinational pass-throughs gated by state and counters, so they carry no
// extra latency and are all 0 outside STREAM.
// -----------------------------------------------------------------------------
module mm_seq_ctrl #(
  parameter logic [11:0] LEN_ADDR  = 12'h010,
  parameter logic [11:0] CTRL_ADDR = 12'h000,
  parameter int          POLL_MAX  = 64,
  parameter int          CW        = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  // command interface
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_in_len,
  input  logic [CW-1:0] cmd_out_len,
  // AXI-Lite write
  output logic          awvalid,
  input  logic          awready,
  output logic [11:0]   awaddr,
  output logic          wvalid,
  input  logic          wready,
  output logic [31:0]   wdata,
  // AXI-Lite read
  output logic          arvalid,
  input  logic          arready,
  output logic [11:0]   araddr,
  input  logic          rvalid,
  output logic          rready,
  input  logic [31:0]   rdata,
  // operand source
  input  logic          src_tvalid,
  output logic          src_tready,
  input  logic [31:0]   src_tdata,
  // accelerator input stream
  output logic          ss_tvalid,
  input  logic          ss_tready,
  output logic [31:0]   ss_tdata,
  output logic          ss_tlast,
  // accelerator output stream
  input  logic          sm_tvalid,
  output logic          sm_tready,
  input  logic [31:0]   sm_tdata,
  input  logic          sm_tlast,
  // result sink
  output logic          dst_tvalid,
  input  logic          dst_tready,
  output logic [31:0]   dst_tdata,
  output logic          dst_tlast,
  // status
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CFG_LEN   = 3'd1,
    ST_CFG_START = 3'd2,
    ST_STREAM    = 3'd3,
    ST_POLL_AR   = 3'd4,
    ST_POLL_R    = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] POLL_LIMIT = CW'(POLL_MAX);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t        state_q,    state_d;
  logic [CW-1:0] in_len_q,   in_len_d;
  logic [CW-1:0] out_len_q,  out_len_d;
  logic [CW-1:0] in_cnt_q,   in_cnt_d;
  logic [CW-1:0] out_cnt_q,  out_cnt_d;
  logic [CW-1:0] poll_cnt_q, poll_cnt_d;
  logic          awvalid_q,  awvalid_d;
  logic          wvalid_q,   wvalid_d;
  logic          arvalid_q,  arvalid_d;
  logic          rready_q,   rready_d;
  logic          busy_q,     busy_d;
  logic          done_q,     done_d;
  logic          err_q,      err_d;
  logic [11:0]   awaddr_q,   awaddr_d;
  logic [11:0]   araddr_q,   araddr_d;
  logic [31:0]   wdata_q,    wdata_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic          in_open_s;
  logic          out_open_s;
  logic          in_last_s;
  logic          out_last_s;
  logic          ss_hs_s;
  logic          dst_hs_s;
  logic          aw_ok_s;
  logic          w_ok_s;
  logic [CW-1:0] poll_next_s;
  logic          unused_rdata_s;

  // Only ap_done (bit 1) of the status word is meaningful here.
  assign unused_rdata_s = ^{rdata[31:2], rdata[0]};

  // Lane gating: a path stays open only while its count is below the latched length.
  always_comb begin
    in_open_s  = 1'b0;
    out_open_s = 1'b0;
    if (state_q == ST_STREAM) begin
      in_open_s  = (in_cnt_q < in_len_q);
      out_open_s = (out_cnt_q < out_len_q);
    end else begin
      in_open_s  = 1'b0;
      out_open_s = 1'b0;
    end
  end

  // A zero length underflows to all-ones here, but the lane is never open then.
  assign in_last_s  = (in_cnt_q == (in_len_q - CNT_ONE));
  assign out_last_s = (out_cnt_q == (out_len_q - CNT_ONE));

  assign ss_tvalid  = in_open_s & src_tvalid;
  assign src_tready = in_open_s & ss_tready;
  assign ss_tdata   = in_open_s ? src_tdata : 32'h0000_0000;
  assign ss_tlast   = in_open_s & in_last_s;
  assign ss_hs_s    = in_open_s & src_tvalid & ss_tready;

  assign dst_tvalid = out_open_s & sm_tvalid;
  assign sm_tready  = out_open_s & dst_tready;
  assign dst_tdata  = out_open_s ? sm_tdata : 32'h0000_0000;
  assign dst_tlast  = out_open_s & out_last_s;
  assign dst_hs_s   = out_open_s & sm_tvalid & dst_tready;

  assign poll_next_s = poll_cnt_q + CNT_ONE;

  assign cmd_ready = (state_q == ST_IDLE);

  // Next-state and next-output computation for the job sequencer.
  always_comb begin
    state_d    = state_q;
    in_len_d   = in_len_q;
    out_len_d  = out_len_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    poll_cnt_d = poll_cnt_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    wdata_d    = wdata_q;
    aw_ok_s    = 1'b0;
    w_ok_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          in_len_d   = cmd_in_len;
          out_len_d  = cmd_out_len;
          in_cnt_d   = CNT_ZERO;
          out_cnt_d  = CNT_ZERO;
          poll_cnt_d = CNT_ZERO;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          awaddr_d   = LEN_ADDR;
          wdata_d    = {{(32-CW){1'b0}}, cmd_in_len};
          state_d    = ST_CFG_LEN;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_CFG_LEN, ST_CFG_START: begin
        // A channel is finished once its valid is low (already accepted) or
        // is being accepted this cycle; each valid drops on its own.
        aw_ok_s   = ~awvalid_q | awready;
        w_ok_s    = ~wvalid_q | wready;
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (aw_ok_s && w_ok_s) begin
          if (state_q == ST_CFG_LEN) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = CTRL_ADDR;
            wdata_d   = 32'h0000_0001;
            state_d   = ST_CFG_START;
          end else begin
            state_d   = ST_STREAM;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_STREAM: begin
        if (ss_hs_s) begin
          in_cnt_d = in_cnt_q + CNT_ONE;
        end else begin
          in_cnt_d = in_cnt_q;
        end
        if (dst_hs_s) begin
          out_cnt_d = out_cnt_q + CNT_ONE;
          // sm_tlast must line up with our own count; a mismatch is sticky
          // for the job but does not stop it.
          if (sm_tlast != out_last_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          out_cnt_d = out_cnt_q;
        end
        // Both lanes closed on entry covers zero lengths in a single cycle.
        if (!in_open_s && !out_open_s) begin
          arvalid_d = 1'b1;
          araddr_d  = CTRL_ADDR;
          state_d   = ST_POLL_AR;
        end else begin
          state_d   = ST_STREAM;
        end
      end

      ST_POLL_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_POLL_R;
        end else begin
          state_d   = ST_POLL_AR;
        end
      end

      ST_POLL_R: begin
        if (rvalid) begin
          rready_d   = 1'b0;
          poll_cnt_d = poll_next_s;
          if (rdata[1]) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (poll_next_s == POLL_LIMIT) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_POLL_AR;
          end
        end else begin
          state_d = ST_POLL_R;
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered AXI-Lite / status outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      in_len_q   <= CNT_ZERO;
      out_len_q  <= CNT_ZERO;
      in_cnt_q   <= CNT_ZERO;
      out_cnt_q  <= CNT_ZERO;
      poll_cnt_q <= CNT_ZERO;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      awaddr_q   <= 12'h000;
      araddr_q   <= 12'h000;
      wdata_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      in_len_q   <= in_len_d;
      out_len_q  <= out_len_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign awvalid = awvalid_q;
  assign wvalid  = wvalid_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign awaddr  = awaddr_q;
  assign araddr  = araddr_q;
  assign wdata   = wdata_q;

endmodule
